msg_streamer: RTL and testbench

MSG_STREAMER -- requirements
Module: msg_streamer

---
 rtl/msg_streamer_if.sv | 27 ++
 rtl/msg_streamer.sv | 130 +++++++++++++
 tb/tb_msg_streamer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/msg_streamer_if.sv
// Handshake bundle between a message streamer and its controller/sink.
// The slave side is the streamer; the master side issues requests and sinks characters.
interface msg_streamer_if #(
    parameter int DATA_W = 8
);
    logic              start;
    logic [1:0]        msg_sel;
    logic              loop_en;
    logic              abort;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, msg_sel, loop_en, abort, out_ready,
        input  out_data, out_valid, out_last, busy, done, err
    );

    modport slave (
        input  start, msg_sel, loop_en, abort, out_ready,
        output out_data, out_valid, out_last, busy, done, err
    );
endinterface

// File: rtl/msg_streamer.sv
// Streams one of a small set of fixed ASCII messages over a valid/ready link,
// optionally looping until aborted.
module msg_streamer #(
    parameter int NUM_MSG = 3,
    parameter int DATA_W  = 8,
    parameter int LEN_W   = 4
) (
    input logic           clk,
    input logic           rst,
    msg_streamer_if.slave bus
);

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    localparam logic [8*12-1:0] MSG0 = "ENGINEERING ";
    localparam logic [8*4-1:0]  MSG1 = "PASS";
    localparam logic [8*4-1:0]  MSG2 = "FAIL";
    localparam logic [8*5-1:0]  MSG3 = "ERROR";

    state_t            state;
    state_t            next_state;
    logic [LEN_W-1:0]  idx;
    logic [1:0]        msg_q;
    logic              loop_q;
    logic [DATA_W-1:0] data_q;
    logic              err_q;

    logic start_ok;
    logic start_bad;
    logic xfer;
    logic at_last;

    function automatic int msg_len(input logic [1:0] m);
        int n;
        case (m)
            2'd0:    n = 12;
            2'd1:    n = 4;
            2'd2:    n = 4;
            default: n = 5;
        endcase
        return n;
    endfunction

    // Positions past the end of a message read as NUL.
    function automatic logic [7:0] char_at(input logic [1:0] m, input logic [LEN_W-1:0] i);
        int         ii;
        logic [7:0] c;
        ii = int'(i);
        c  = 8'h00;
        case (m)
            2'd0:    if (ii < 12) c = MSG0[8*(11-ii) +: 8];
            2'd1:    if (ii < 4)  c = MSG1[8*(3-ii) +: 8];
            2'd2:    if (ii < 4)  c = MSG2[8*(3-ii) +: 8];
            default: if (ii < 5)  c = MSG3[8*(4-ii) +: 8];
        endcase
        return c;
    endfunction

    assign start_ok  = (state == IDLE) && bus.start && (int'(bus.msg_sel) < NUM_MSG);
    assign start_bad = (state == IDLE) && bus.start && (int'(bus.msg_sel) >= NUM_MSG);
    assign xfer      = (state == STREAM) && bus.out_ready;
    assign at_last   = (int'(idx) == msg_len(msg_q) - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Abort outranks both the loop wrap and completion on the final transfer.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_ok) next_state = STREAM;
            STREAM: begin
                if (bus.abort) begin
                    next_state = IDLE;
                end else if (xfer && at_last && !loop_q) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.out_valid = (state == STREAM);
        bus.out_last  = (state == STREAM) && at_last;
        bus.busy      = (state != IDLE);
        bus.done      = (state == DONE);
        bus.err       = err_q;
        bus.out_data  = data_q;
    end

    // Character register is preloaded one step ahead so each transfer exposes the next character immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx    <= '0;
            msg_q  <= 2'd0;
            loop_q <= 1'b0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= start_bad;
            if (start_ok) begin
                msg_q  <= bus.msg_sel;
                loop_q <= bus.loop_en;
                idx    <= '0;
                data_q <= DATA_W'(char_at(bus.msg_sel, '0));
            end else if (state == STREAM) begin
                if (bus.abort) begin
                    idx    <= '0;
                    data_q <= '0;
                end else if (xfer) begin
                    if (at_last) begin
                        idx    <= '0;
                        data_q <= loop_q ? DATA_W'(char_at(msg_q, '0)) : '0;
                    end else begin
                        idx    <= idx + LEN_W'(1);
                        data_q <= DATA_W'(char_at(msg_q, idx + LEN_W'(1)));
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_msg_streamer.sv
// Self-checking bench for msg_streamer: a cycle table, directed corner sequences
// and randomized episodes scored against the message strings themselves.
module tb_msg_streamer;

    localparam int DATA_W = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    msg_streamer_if #(.DATA_W(DATA_W)) bus();

    msg_streamer #(.NUM_MSG(3), .DATA_W(DATA_W), .LEN_W(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int vectors_applied = 0;
    int miscompares     = 0;

    string msgs[4] = '{"ENGINEERING ", "PASS", "FAIL", "ERROR"};

    typedef struct packed {
        logic       start;
        logic [1:0] sel;
        logic       loop_en;
        logic       abort;
        logic       ready;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_last;
        logic       exp_busy;
        logic       exp_done;
        logic       exp_err;
    } vec_t;

    vec_t vecs[12];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors_applied++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic s, input logic [1:0] sel, input logic lp,
                                  input logic ab, input logic rdy);
        bus.start     = s;
        bus.msg_sel   = sel;
        bus.loop_en   = lp;
        bus.abort     = ab;
        bus.out_ready = rdy;
    endtask

    task automatic check_all(input string tag, input logic v, input logic [7:0] d, input logic l,
                             input logic b, input logic dn, input logic e);
        check_output({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
        check_output({tag, ".data"},  32'(bus.out_data),  32'(d));
        check_output({tag, ".last"},  32'(bus.out_last),  32'(l));
        check_output({tag, ".busy"},  32'(bus.busy),      32'(b));
        check_output({tag, ".done"},  32'(bus.done),      32'(dn));
        check_output({tag, ".err"},   32'(bus.err),       32'(e));
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] eng[12];
        eng = '{8'h45, 8'h4E, 8'h47, 8'h49, 8'h4E, 8'h45, 8'h45, 8'h52, 8'h49, 8'h4E, 8'h47, 8'h20};

        // Cycle table: inputs for one cycle, outputs expected in the following cycle.
        //            st  sel   lp  ab  rdy  val  data   last busy done err
        vecs[0]  = '{1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 8'h46, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 8'h41, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 8'h41, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 8'h49, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 8'h49, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 8'h4C, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 8'h4C, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};

        apply_stimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        step();
        check_all("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            apply_stimulus(vecs[i].start, vecs[i].sel, vecs[i].loop_en, vecs[i].abort, vecs[i].ready);
            step();
            check_all($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_data, vecs[i].exp_last,
                      vecs[i].exp_busy, vecs[i].exp_done, vecs[i].exp_err);
        end

        // msg0 with start held high throughout streaming and the done cycle.
        apply_stimulus(1'b1, 2'd0, 1'b0, 1'b0, 1'b1);
        step();
        for (int k = 0; k < 12; k++) begin
            check_all($sformatf("eng%0d", k), 1'b1, eng[k], (k == 11), 1'b1, 1'b0, 1'b0);
            step();
        end
        check_all("eng_done", 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        check_all("eng_idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        step();

        // Looping PASS, then abort on the tenth character.
        apply_stimulus(1'b1, 2'd1, 1'b1, 1'b0, 1'b1);
        step();
        bus.start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            check_all($sformatf("loop%0d", k), 1'b1, msgs[1][k % 4], ((k % 4) == 3), 1'b1, 1'b0, 1'b0);
            if (k == 9) bus.abort = 1'b1;
            step();
        end
        check_all("loop_abort", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.abort = 1'b0;
        step();
        check_output("loop_nodone", 32'(bus.done), 32'd0);

        // Reset mid-stream overrides a simultaneous start, then a fresh start runs cleanly.
        apply_stimulus(1'b1, 2'd0, 1'b0, 1'b0, 1'b1);
        step();
        bus.start = 1'b0;
        for (int k = 0; k < 4; k++) step();
        check_output("rst_pre_char", 32'(bus.out_data), 32'h4E);
        rst = 1'b1;
        apply_stimulus(1'b1, 2'd2, 1'b0, 1'b1, 1'b1);
        step();
        check_all("rst_mid", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        apply_stimulus(1'b1, 2'd1, 1'b0, 1'b0, 1'b1);
        step();
        check_all("rst_fresh", 1'b1, 8'h50, 1'b0, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
        step();
        check_output("rst_fresh_abort", 32'(bus.busy), 32'd0);
        bus.abort = 1'b0;

        // Random episodes: the sink must see the message text repeated, nothing else.
        for (int ep = 0; ep < 80; ep++) begin
            int         sel;
            int         len;
            int         k;
            int         abort_cyc;
            logic       lp;
            logic       rdy;
            logic       ab;
            logic       finished;

            sel = $urandom_range(3, 0);
            lp  = 1'($urandom % 2);
            apply_stimulus(1'b1, 2'(sel), lp, 1'b0, 1'($urandom % 2));
            step();
            if (sel >= 3) begin
                check_all($sformatf("ep%0d_err", ep), 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
                apply_stimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
                step();
                check_output($sformatf("ep%0d_err_clear", ep), 32'(bus.err), 32'd0);
                continue;
            end

            len       = msgs[sel].len();
            k         = 0;
            finished  = 1'b0;
            abort_cyc = lp ? $urandom_range(40, 1) : ((($urandom % 4) == 0) ? $urandom_range(20, 1) : 100000);
            bus.start = 1'b0;

            for (int c = 0; c < 300 && !finished; c++) begin
                check_output($sformatf("ep%0d_c%0d_valid", ep, c), 32'(bus.out_valid), 32'd1);
                check_output($sformatf("ep%0d_c%0d_data", ep, c), 32'(bus.out_data), 32'(msgs[sel][k % len]));
                check_output($sformatf("ep%0d_c%0d_last", ep, c), 32'(bus.out_last), 32'((k % len) == len - 1));
                check_output($sformatf("ep%0d_c%0d_done", ep, c), 32'(bus.done), 32'd0);
                rdy = 1'($urandom % 2);
                ab  = (c >= abort_cyc);
                bus.start     = 1'($urandom % 2);
                bus.msg_sel   = 2'($urandom);
                bus.out_ready = rdy;
                bus.abort     = ab;
                step();
                if (ab) begin
                    check_all($sformatf("ep%0d_abort", ep), 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
                    finished = 1'b1;
                end else if (rdy) begin
                    k++;
                    if (!lp && k == len) begin
                        check_all($sformatf("ep%0d_done", ep), 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
                        bus.start = 1'($urandom % 2);
                        bus.abort = 1'($urandom % 2);
                        step();
                        check_all($sformatf("ep%0d_idle", ep), 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
                        finished = 1'b1;
                    end
                end
            end

            if (!finished) begin
                check_output($sformatf("ep%0d_timeout", ep), 32'd0, 32'd1);
                rst = 1'b1;
                step();
                rst = 1'b0;
            end
            apply_stimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
